// File: rtl/ddr3_mch_pkg.sv
// ddr3_mch_pkg
//   Shared types and helpers for the multi-channel DDR3 frame-buffer arbiter.
//   - state_t  : scheduler FSM state encoding (also exported for debug).
//   - buf_addr : word address of (channel, ping-pong buffer, offset) inside
//                the frame-buffer region. The layout is
//                base + (2*ch + b)*frame_words + off.
//                The arithmetic is 64 bits wide. Callers truncate the result
//                to ADDR_W, which gives the modulo-2^ADDR_W wrap.
package ddr3_mch_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4
    } state_t;

    function automatic logic [63:0] buf_addr(
        input logic [63:0] base,
        input logic [63:0] ch,
        input logic        b,
        input logic [63:0] frame_words,
        input logic [63:0] off
    );
        return base + (((ch << 1) + 64'(b)) * frame_words) + off;
    endfunction

endpackage

// File: rtl/ddr3_mch_rw_arb_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Search starts at ptr+1 and wraps.
//   The first requesting index found after the pointer wins.
//   Ports:
//     req     in  N  request vector
//     ptr     in  W  index of the previous winner
//     gnt_idx out W  winning index (0 when no request)
//     any     out 1  at least one request present
module rr_arbiter
    import ddr3_mch_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    // Walk from the farthest candidate (ptr+N, i.e. ptr itself) down to the
    // nearest (ptr+1). The last hit overwrites earlier ones, so the nearest
    // index after the pointer wins without an early exit.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = W'(idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_mch_rw_arb.sv
// ddr3_mch_rw_arb
//   N-channel DDR3 frame-buffer scheduler. It issues single-burst write
//   requests that drain CH_NUM camera FIFOs. It issues read requests that
//   fill one display FIFO. Each channel has a ping-pong frame pair. The
//   display side reads the last completed buffer of the selected channel.
//
//   Handshake with the AXI master: wd_req/rd_req is a one-cycle start pulse.
//   The matching addr/len (and wd_ch) are registered before the pulse and
//   held until the next burst is scheduled. The master answers with a
//   one-cycle *_finish pulse. A finish pulse outside *_WAIT is ignored.
//
//   Ports: clk/rst_n (sync, active low); ddr3_init_done gates scheduling;
//   ddr3_pingpang_en; ddr3_read_valid; addr_base/frame_words region layout;
//   wd_/rd_burst_len; wd_load[CH_NUM] and rd_load frame-start levels;
//   wfifo_rcount (packed levels); rd_ch_sel; rfifo_wcount; request outputs
//   wd_/rd_req, _addr, _len, wd_ch; wd_/rd_finish inputs;
//   dbg_state exposes the FSM state.
module ddr3_mch_rw_arb
    import ddr3_mch_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 10,
    parameter int CNT_W  = 11,
    parameter int RD_LOW = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ddr3_init_done,
    input  logic                    ddr3_pingpang_en,
    input  logic                    ddr3_read_valid,
    input  logic [ADDR_W-1:0]       addr_base,
    input  logic [ADDR_W-1:0]       frame_words,
    input  logic [LEN_W-1:0]        wd_burst_len,
    input  logic [LEN_W-1:0]        rd_burst_len,
    input  logic [CH_NUM-1:0]       wd_load,
    input  logic [CH_NUM*CNT_W-1:0] wfifo_rcount,
    input  logic                    rd_load,
    input  logic [CH_W-1:0]         rd_ch_sel,
    input  logic [CNT_W-1:0]        rfifo_wcount,
    output logic                    wd_req,
    output logic                    rd_req,
    output logic [ADDR_W-1:0]       wd_addr,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [LEN_W-1:0]        wd_len,
    output logic [LEN_W-1:0]        rd_len,
    output logic [CH_W-1:0]         wd_ch,
    input  logic                    wd_finish,
    input  logic                    rd_finish,
    output state_t                  dbg_state
);

    state_t state, state_nxt;

    logic [CH_NUM-1:0] wd_load_q, load_pend, wr_buf, done_buf;
    logic [ADDR_W-1:0] wr_off [CH_NUM];
    logic [CH_W-1:0]   last_wr_ch;

    logic              rd_load_q, rd_pend, rd_buf;
    logic [CH_W-1:0]   rd_pend_ch, rd_ch;
    logic [ADDR_W-1:0] rd_off;

    // Offset after a burst. It wraps to 0 when the following burst would
    // cross the end of the buffer.
    function automatic logic [ADDR_W-1:0] next_off(
        input logic [ADDR_W-1:0] off,
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] fw
    );
        logic [ADDR_W:0] reach;
        reach = (ADDR_W+1)'(off) + (ADDR_W+1)'(len) + (ADDR_W+1)'(len);
        if (reach > (ADDR_W+1)'(fw)) return '0;
        return off + ADDR_W'(len);
    endfunction

    // Frame-start handling. A pending write load is held off while its
    // channel owns the current write burst. "eff_*" are the values that the
    // per-channel registers hold after this edge. They are used to latch the
    // burst address when a load and a grant coincide.
    logic [CH_NUM-1:0] wd_rise, wr_apply, eff_buf, elig;
    logic [ADDR_W-1:0] eff_off [CH_NUM];
    logic              wr_active, rd_active;

    assign wd_rise   = wd_load & ~wd_load_q;
    assign wr_active = (state == WR_ISSUE) || (state == WR_WAIT);
    assign rd_active = (state == RD_ISSUE) || (state == RD_WAIT);

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            wr_apply[i] = (load_pend[i] | wd_rise[i]) &&
                          !(wr_active && (wd_ch == CH_W'(i)));
            eff_buf[i]  = wr_apply[i] ? (ddr3_pingpang_en & ~wr_buf[i]) : wr_buf[i];
            eff_off[i]  = wr_apply[i] ? '0 : wr_off[i];
            elig[i]     = 32'(wfifo_rcount[i*CNT_W +: CNT_W]) >= 32'(wd_burst_len);
        end
    end

    // A display load during a read burst takes effect at that burst's finish.
    logic            rd_rise, rd_apply, eff_rd_buf;
    logic [CH_W-1:0] rd_sel_eff, eff_rd_ch;
    logic [ADDR_W-1:0] eff_rd_off;

    assign rd_rise    = rd_load & ~rd_load_q;
    assign rd_sel_eff = rd_rise ? rd_ch_sel : rd_pend_ch;
    assign rd_apply   = (rd_pend | rd_rise) &&
                        (!rd_active || ((state == RD_WAIT) && rd_finish));
    assign eff_rd_ch  = rd_apply ? rd_sel_eff : rd_ch;
    assign eff_rd_buf = rd_apply ? (ddr3_pingpang_en & done_buf[rd_sel_eff]) : rd_buf;
    assign eff_rd_off = rd_apply ? '0 : rd_off;

    logic [CH_W-1:0] gnt_idx;
    logic            gnt_any;

    rr_arbiter #(.N(CH_NUM), .W(CH_W)) u_rr (
        .req     (elig),
        .ptr     (last_wr_ch),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    logic rd_urgent, rd_room;
    assign rd_urgent = ddr3_read_valid && (32'(rfifo_wcount) < 32'(RD_LOW));
    assign rd_room   = ddr3_read_valid &&
                       ((32'(rfifo_wcount) + 32'(rd_burst_len)) < (32'd1 << CNT_W));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ddr3_init_done) begin
                    if (rd_urgent)    state_nxt = RD_ISSUE;
                    else if (gnt_any) state_nxt = WR_ISSUE;
                    else if (rd_room) state_nxt = RD_ISSUE;
                end
            end
            WR_ISSUE: state_nxt = WR_WAIT;
            WR_WAIT:  if (wd_finish) state_nxt = IDLE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (rd_finish) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    logic take_wr, take_rd;
    assign take_wr = (state == IDLE) && (state_nxt == WR_ISSUE);
    assign take_rd = (state == IDLE) && (state_nxt == RD_ISSUE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wd_load_q  <= '0;
            load_pend  <= '0;
            wr_buf     <= '0;
            done_buf   <= '0;
            last_wr_ch <= CH_W'(CH_NUM - 1);
            rd_load_q  <= 1'b0;
            rd_pend    <= 1'b0;
            rd_pend_ch <= '0;
            rd_ch      <= '0;
            rd_buf     <= 1'b0;
            rd_off     <= '0;
            wd_addr    <= '0;
            rd_addr    <= '0;
            wd_len     <= '0;
            rd_len     <= '0;
            wd_ch      <= '0;
            for (int i = 0; i < CH_NUM; i++) wr_off[i] <= '0;
        end else begin
            state     <= state_nxt;
            wd_load_q <= wd_load;
            rd_load_q <= rd_load;

            if (take_wr) begin
                wd_ch      <= gnt_idx;
                last_wr_ch <= gnt_idx;
                wd_len     <= wd_burst_len;
                wd_addr    <= ADDR_W'(buf_addr(64'(addr_base), 64'(gnt_idx), eff_buf[gnt_idx],
                                               64'(frame_words), 64'(eff_off[gnt_idx])));
            end
            if (take_rd) begin
                rd_len  <= rd_burst_len;
                rd_addr <= ADDR_W'(buf_addr(64'(addr_base), 64'(eff_rd_ch), eff_rd_buf,
                                            64'(frame_words), 64'(eff_rd_off)));
            end

            // The offset advances first. A load applied in the same cycle
            // then overrides it.
            for (int i = 0; i < CH_NUM; i++) begin
                if ((state == WR_WAIT) && wd_finish && (wd_ch == CH_W'(i)))
                    wr_off[i] <= next_off(wr_off[i], wd_len, frame_words);
                if (wr_apply[i]) begin
                    wr_off[i]    <= '0;
                    load_pend[i] <= 1'b0;
                    done_buf[i]  <= ddr3_pingpang_en & wr_buf[i];
                    wr_buf[i]    <= ddr3_pingpang_en & ~wr_buf[i];
                end else if (wd_rise[i]) begin
                    load_pend[i] <= 1'b1;
                end
            end

            if ((state == RD_WAIT) && rd_finish)
                rd_off <= next_off(rd_off, rd_len, frame_words);
            if (rd_apply) begin
                rd_ch   <= rd_sel_eff;
                rd_buf  <= eff_rd_buf;
                rd_off  <= '0;
                rd_pend <= 1'b0;
            end else if (rd_rise) begin
                rd_pend    <= 1'b1;
                rd_pend_ch <= rd_ch_sel;
            end
        end
    end

    assign wd_req    = (state == WR_ISSUE);
    assign rd_req    = (state == RD_ISSUE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ddr3_mch_rw_arb.sv
// Directed bench for ddr3_mch_rw_arb (CH_NUM=4). Expected addresses are
// hand-computed from base + (2*ch+b)*frame_words + offset.
module tb_ddr3_mch_rw_arb;
    import ddr3_mch_pkg::*;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;
    localparam int ADDR_W = 28;
    localparam int LEN_W  = 10;
    localparam int CNT_W  = 11;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    ddr3_init_done, ddr3_pingpang_en, ddr3_read_valid;
    logic [ADDR_W-1:0]       addr_base, frame_words;
    logic [LEN_W-1:0]        wd_burst_len, rd_burst_len;
    logic [CH_NUM-1:0]       wd_load;
    logic [CH_NUM*CNT_W-1:0] wfifo_rcount;
    logic                    rd_load;
    logic [CH_W-1:0]         rd_ch_sel;
    logic [CNT_W-1:0]        rfifo_wcount;
    logic                    wd_req, rd_req;
    logic [ADDR_W-1:0]       wd_addr, rd_addr;
    logic [LEN_W-1:0]        wd_len, rd_len;
    logic [CH_W-1:0]         wd_ch;
    logic                    wd_finish, rd_finish;
    state_t                  dbg_state;

    int checks   = 0;
    int failures = 0;

    ddr3_mch_rw_arb #(
        .CH_NUM(CH_NUM), .CH_W(CH_W), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .CNT_W(CNT_W), .RD_LOW(256)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ddr3_init_done(ddr3_init_done), .ddr3_pingpang_en(ddr3_pingpang_en),
        .ddr3_read_valid(ddr3_read_valid),
        .addr_base(addr_base), .frame_words(frame_words),
        .wd_burst_len(wd_burst_len), .rd_burst_len(rd_burst_len),
        .wd_load(wd_load), .wfifo_rcount(wfifo_rcount),
        .rd_load(rd_load), .rd_ch_sel(rd_ch_sel), .rfifo_wcount(rfifo_wcount),
        .wd_req(wd_req), .rd_req(rd_req),
        .wd_addr(wd_addr), .rd_addr(rd_addr),
        .wd_len(wd_len), .rd_len(rd_len), .wd_ch(wd_ch),
        .wd_finish(wd_finish), .rd_finish(rd_finish),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic init_inputs();
        ddr3_init_done   = 1'b1;
        ddr3_pingpang_en = 1'b0;
        ddr3_read_valid  = 1'b0;
        addr_base        = '0;
        frame_words      = 28'd4096;
        wd_burst_len     = 10'd64;
        rd_burst_len     = 10'd64;
        wd_load          = '0;
        wfifo_rcount     = '0;
        rd_load          = 1'b0;
        rd_ch_sel        = '0;
        rfifo_wcount     = '0;
        wd_finish        = 1'b0;
        rd_finish        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Driver tasks
    task automatic set_levels(input int l0, input int l1, input int l2, input int l3);
        wfifo_rcount = {11'(l3), 11'(l2), 11'(l1), 11'(l0)};
    endtask

    // Waits (bounded) for the next request pulse, observed on a falling edge.
    task automatic wait_req(output logic got_wr, output logic got_rd,
                            output logic timeout, output int cycles);
        got_wr  = 1'b0;
        got_rd  = 1'b0;
        timeout = 1'b1;
        cycles  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cycles++;
            if (wd_req || rd_req) begin
                got_wr  = wd_req;
                got_rd  = rd_req;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic finish_wr();
        @(negedge clk);
        wd_finish = 1'b1;
        @(negedge clk);
        wd_finish = 1'b0;
    endtask

    task automatic finish_rd();
        @(negedge clk);
        rd_finish = 1'b1;
        @(negedge clk);
        rd_finish = 1'b0;
    endtask

    task automatic pulse_wd_load(input logic [CH_NUM-1:0] m);
        wd_load = m;
        repeat (2) @(negedge clk);
        wd_load = '0;
        @(negedge clk);
    endtask

    task automatic pulse_rd_load(input logic [CH_W-1:0] sel);
        rd_ch_sel = sel;
        rd_load   = 1'b1;
        repeat (2) @(negedge clk);
        rd_load = 1'b0;
        @(negedge clk);
    endtask

    // Scenarios
    task automatic test_reset();
        init_inputs();
        do_reset();
        @(negedge clk);
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        checks++; if ({wd_req, rd_req} !== 2'b00) begin failures++; $display("FAIL reset_req: got %b expected 00", {wd_req, rd_req}); end
        checks++; if ({wd_addr, rd_addr, wd_len, rd_len, wd_ch} !== '0) begin failures++; $display("FAIL reset_outputs: got wd_addr=%0d rd_addr=%0d wd_len=%0d rd_len=%0d wd_ch=%0d expected all 0", wd_addr, rd_addr, wd_len, rd_len, wd_ch); end
    endtask

    task automatic test_round_robin();
        logic gw, gr, to;
        int   cyc;
        int   exp_addr;
        init_inputs();
        set_levels(64, 64, 64, 64);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_req(gw, gr, to, cyc);
            exp_addr = (k == 4) ? 64 : k * 8192;
            checks++; if (to || !gw || gr) begin failures++; $display("FAIL rr_req%0d: got wr=%b rd=%b timeout=%b expected write only", k, gw, gr, to); end
            checks++; if (wd_ch !== CH_W'(k % 4)) begin failures++; $display("FAIL rr_ch%0d: got %0d expected %0d", k, wd_ch, k % 4); end
            checks++; if (wd_addr !== ADDR_W'(exp_addr)) begin failures++; $display("FAIL rr_addr%0d: got %0d expected %0d", k, wd_addr, exp_addr); end
            checks++; if (wd_len !== 10'd64) begin failures++; $display("FAIL rr_len%0d: got %0d expected 64", k, wd_len); end
            if (k > 0) begin
                checks++; if (cyc != 1) begin failures++; $display("FAIL rr_gap%0d: got %0d expected 1", k, cyc); end
            end
            if (k == 4) set_levels(0, 0, 0, 0);
            finish_wr();
        end
    endtask

    task automatic test_read_priority();
        logic gw, gr, to;
        int   cyc;
        init_inputs();
        set_levels(64, 64, 64, 64);
        ddr3_read_valid = 1'b1;
        rfifo_wcount    = 11'd100;
        do_reset();
        wait_req(gw, gr, to, cyc);
        checks++; if (to || !gr || gw) begin failures++; $display("FAIL urgent_first: got wr=%b rd=%b timeout=%b expected read only", gw, gr, to); end
        checks++; if (rd_addr !== 28'd0) begin failures++; $display("FAIL urgent_addr: got %0d expected 0", rd_addr); end
        checks++; if (rd_len !== 10'd64) begin failures++; $display("FAIL urgent_len: got %0d expected 64", rd_len); end
        set_levels(0, 0, 0, 0);
        rfifo_wcount = 11'd2000;
        finish_rd();
        wait_req(gw, gr, to, cyc);
        checks++; if (!to) begin failures++; $display("FAIL read_full_idle: got wr=%b rd=%b expected no request", gw, gr); end
        rfifo_wcount = 11'd1500;
        wait_req(gw, gr, to, cyc);
        checks++; if (to || !gr) begin failures++; $display("FAIL read_room: got rd=%b timeout=%b expected read", gr, to); end
        checks++; if (rd_addr !== 28'd64) begin failures++; $display("FAIL read_room_addr: got %0d expected 64", rd_addr); end
        set_levels(64, 0, 0, 0);
        finish_rd();
        wait_req(gw, gr, to, cyc);
        checks++; if (to || !gw || gr) begin failures++; $display("FAIL write_over_room: got wr=%b rd=%b timeout=%b expected write", gw, gr, to); end
        set_levels(0, 0, 0, 0);
        ddr3_read_valid = 1'b0;
        finish_wr();
    endtask

    task automatic test_pingpong();
        logic gw, gr, to;
        int   cyc;
        init_inputs();
        ddr3_pingpang_en = 1'b1;
        do_reset();
        pulse_wd_load(4'b0010);
        pulse_rd_load(2'd1);
        ddr3_read_valid = 1'b1;
        rfifo_wcount    = 11'd100;
        wait_req(gw, gr, to, cyc);
        ddr3_read_valid = 1'b0;
        checks++; if (to || !gr || rd_addr !== 28'd8192) begin failures++; $display("FAIL pp_rd_done0: got rd=%b addr=%0d expected read at 8192", gr, rd_addr); end
        finish_rd();
        set_levels(0, 64, 0, 0);
        wait_req(gw, gr, to, cyc);
        set_levels(0, 0, 0, 0);
        checks++; if (to || !gw || wd_ch !== 2'd1 || wd_addr !== 28'd12288) begin failures++; $display("FAIL pp_wr_buf1: got ch=%0d addr=%0d expected ch1 at 12288", wd_ch, wd_addr); end
        finish_wr();
        pulse_wd_load(4'b0010);
        pulse_rd_load(2'd1);
        ddr3_read_valid = 1'b1;
        wait_req(gw, gr, to, cyc);
        ddr3_read_valid = 1'b0;
        checks++; if (to || !gr || rd_addr !== 28'd12288) begin failures++; $display("FAIL pp_rd_done1: got rd=%b addr=%0d expected read at 12288", gr, rd_addr); end
        finish_rd();
        set_levels(0, 64, 0, 0);
        wait_req(gw, gr, to, cyc);
        set_levels(0, 0, 0, 0);
        checks++; if (to || !gw || wd_addr !== 28'd8192) begin failures++; $display("FAIL pp_wr_buf0: got wr=%b addr=%0d expected 8192", gw, wd_addr); end
        finish_wr();
    endtask

    task automatic test_load_during_burst();
        logic gw, gr, to;
        int   cyc;
        init_inputs();
        ddr3_pingpang_en = 1'b1;
        set_levels(64, 0, 0, 0);
        do_reset();
        wait_req(gw, gr, to, cyc);
        checks++; if (to || wd_addr !== 28'd0) begin failures++; $display("FAIL ldb_first: got %0d expected 0", wd_addr); end
        finish_wr();
        wait_req(gw, gr, to, cyc);
        checks++; if (to || wd_addr !== 28'd64) begin failures++; $display("FAIL ldb_second: got %0d expected 64", wd_addr); end
        wd_load = 4'b0001;
        finish_wr();
        wait_req(gw, gr, to, cyc);
        checks++; if (to || wd_addr !== 28'd4096) begin failures++; $display("FAIL ldb_after_load: got %0d expected 4096", wd_addr); end
        set_levels(0, 0, 0, 0);
        wd_load = '0;
        finish_wr();
    endtask

    task automatic test_wrap();
        logic gw, gr, to;
        int   cyc;
        int   exp_off[5] = '{0, 64, 128, 0, 64};
        init_inputs();
        frame_words = 28'd200;
        set_levels(64, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_req(gw, gr, to, cyc);
            checks++; if (to || wd_addr !== ADDR_W'(exp_off[k])) begin failures++; $display("FAIL wrap_off%0d: got %0d expected %0d", k, wd_addr, exp_off[k]); end
            if (k == 4) set_levels(0, 0, 0, 0);
            finish_wr();
        end
    endtask

    task automatic test_init_and_reset();
        logic gw, gr, to;
        int   cyc;
        init_inputs();
        ddr3_init_done = 1'b0;
        addr_base      = 28'd1000;
        set_levels(0, 0, 64, 0);
        do_reset();
        wd_finish = 1'b1;
        rd_finish = 1'b1;
        @(negedge clk);
        wd_finish = 1'b0;
        rd_finish = 1'b0;
        wait_req(gw, gr, to, cyc);
        checks++; if (!to) begin failures++; $display("FAIL init_gate: got wr=%b rd=%b expected no request", gw, gr); end
        ddr3_init_done = 1'b1;
        wait_req(gw, gr, to, cyc);
        checks++; if (to || wd_ch !== 2'd2 || wd_addr !== 28'd17384) begin failures++; $display("FAIL init_release: got ch=%0d addr=%0d expected ch2 at 17384", wd_ch, wd_addr); end
        @(negedge clk);
        checks++; if (dbg_state !== WR_WAIT) begin failures++; $display("FAIL in_wr_wait: got %0d expected %0d", dbg_state, WR_WAIT); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({wd_req, rd_req} !== 2'b00 || {wd_addr, rd_addr, wd_len, rd_len, wd_ch} !== '0) begin failures++; $display("FAIL mid_reset_outputs: got wd_addr=%0d wd_len=%0d wd_ch=%0d expected 0", wd_addr, wd_len, wd_ch); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL mid_reset_state: got %0d expected %0d", dbg_state, IDLE); end
        rst_n = 1'b1;
        set_levels(0, 0, 0, 0);
        @(negedge clk);
    endtask

    // Sequencer and final report
    initial begin
        rst_n = 1'b0;
        init_inputs();
        test_reset();
        test_round_robin();
        test_read_priority();
        test_pingpong();
        test_load_during_burst();
        test_wrap();
        test_init_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_mch_rw_arb.md
# ddr3_mch_rw_arb

Parametrised N-channel DDR3 frame-buffer arbiter for the multi-camera video path: schedules burst writes from `CH_NUM` camera write-FIFOs and burst reads into one display read-FIFO, issuing single-burst requests to `aq_axi_master`. It generalises the two-camera read/write control to any channel count. Each channel has its own ping-pong frame pair. The display side reads the most recently completed frame of a runtime-selected channel.

## Interface
Parameters:
- `CH_NUM`, 4: number of camera write channels (2..8).
- `CH_W`, `$clog2(CH_NUM)`: channel index width (minimum 1).
- `ADDR_W`, 28: DDR word-address width (128-bit words, before the master's `<<3`).
- `LEN_W`, 10: burst length width in 128-bit words.
- `CNT_W`, 11: FIFO level width.
- `RD_LOW`, 256: read-FIFO level below which read is urgent.

Ports (single clock `clk`; `rst_n` synchronous, active-low):
- `clk`  in  1  ui_clk domain clock.
- `rst_n`  in  1  synchronous active-low reset.
- `ddr3_init_done`  in  1  no request issued while 0.
- `ddr3_pingpang_en`  in  1  1 = ping-pong per channel, 0 = buffer 0 only.
- `ddr3_read_valid`  in  1  display read enable.
- `addr_base`  in  ADDR_W  start of frame-buffer region.
- `frame_words`  in  ADDR_W  words per frame buffer.
- `wd_burst_len`, `rd_burst_len`  in  LEN_W  burst size in words (≥1).
- `wd_load`  in  CH_NUM  per-channel frame-start level, already in `clk` domain.
- `wfifo_rcount`  in  CH_NUM*CNT_W  packed write-FIFO read-side levels.
- `rd_load`  in  1  display frame-start level.
- `rd_ch_sel`  in  CH_W  channel to display.
- `rfifo_wcount`  in  CNT_W  read-FIFO write-side level.
- `wd_req`, `rd_req`  out  1  one-cycle burst start pulse.
- `wd_addr`, `rd_addr`  out  ADDR_W  burst word address.
- `wd_len`, `rd_len`  out  LEN_W  burst length.
- `wd_ch`  out  CH_W  channel owning current write burst (FIFO mux select).
- `wd_finish`, `rd_finish`  in  1  burst-complete pulse from master.

## Operation
- Buffer address: `addr_base + (2*ch + b)*frame_words + offset`. Display read of channel `ch`, buffer `b` uses the same formula. Arithmetic is ADDR_W wide, modulo 2^ADDR_W.
- Per-channel state: `wr_buf[ch]`, `wr_off[ch]`, `done_buf[ch]` (last completed buffer), `load_pend[ch]`.
- Rising edge of `wd_load[ch]`: `load_pend[ch]<=1`. Pending load is applied when channel `ch` is not the active write burst:
  - `wr_off<=0`.
  - If pingpang, `done_buf<=wr_buf` and `wr_buf<=~wr_buf`.
  - Otherwise `done_buf<=0` and `wr_buf<=0`.
- Rising edge of `rd_load`: latch `rd_ch<=rd_ch_sel`, `rd_buf<=done_buf[rd_ch_sel]` (0 if not pingpang), `rd_off<=0`. If a read burst is active, apply at `rd_finish`.
- Offsets advance by burst length on the matching `*_finish`. If `off+len+len > frame_words`, the offset wraps to 0, so no burst crosses a buffer end.
- FSM states: `IDLE`, `WR_ISSUE`, `WR_WAIT`, `RD_ISSUE`, `RD_WAIT`.
  - `IDLE`, urgent read (`ddr3_read_valid && rfifo_wcount < RD_LOW`): go to `RD_ISSUE`.
  - Otherwise, if any channel has `wfifo_rcount >= wd_burst_len`: round-robin starting at `last_wr_ch+1`, lowest eligible index after the pointer wins, go to `WR_ISSUE`.
  - Otherwise, non-urgent read (`ddr3_read_valid && rfifo_wcount < 2^CNT_W - rd_burst_len`): go to `RD_ISSUE`.
  - `*_ISSUE`: pulse req for one cycle, hold addr/len/`wd_ch` stable, go to `*_WAIT`.
  - `*_WAIT`: on finish, update offset, go to `IDLE`.
- `ddr3_init_done=0` holds the FSM in `IDLE`. A finish pulse in the wrong state is ignored.
- Reset: all outputs 0; all offsets, buffers and pend flags 0; `last_wr_ch=CH_NUM-1`.

## Timing
- Decision in `IDLE` → req pulse the next cycle (`*_ISSUE`). Minimum inter-burst gap is 2 cycles after finish.
- `wd_addr`, `wd_len`, `wd_ch` stay valid from the req cycle until the cycle after finish.
- Level inputs are sampled each cycle. Edge detect adds 1 cycle.
- Simultaneous `wd_load[ch]` and `wd_finish` for ch: offset update is applied first, then the load, in the same cycle.
- `rst_n` low mid-burst: immediate return to `IDLE`. The master is reset by the same `rst_n`.

## Structure
- Package `ddr3_mch_pkg`: FSM state enum and a `buf_addr(base, ch, b, frame_words, off)` function.
- One sub-module: `rr_arbiter` (CH_NUM request vector, pointer in, one-hot/index grant out, combinational).

## Test plan
- CH_NUM=4, base=0, frame_words=4096, len=64. Channels 0..3 all at level 64 → grants 0,1,2,3,0 in order; `wd_addr` of ch2 buffer 0 = 16384.
- `rfifo_wcount=100`, `ddr3_read_valid=1`, all write channels eligible → read issued before any write.
- Pingpang on: ch1 `wd_load` edge twice → `wr_buf` 0→1→0, `done_buf` 0 then 1. Then `rd_load` with `rd_ch_sel=1` → `rd_addr=(2+1)*4096=12288`.
- `wd_load[0]` during ch0 `WR_WAIT` → offset keeps advancing to the finish value, then resets to 0 on the cycle after finish.
- frame_words=200, len=64 → offsets 0,64,128,0: wrap, no address ≥ buffer end.
- `ddr3_init_done=0` with all FIFOs eligible → no req. `rst_n` low mid-`WR_WAIT` → all outputs 0 the next cycle.
